// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Shared constants and helpers for the parametrised register file.
//   REG_WIDTH / REG_DEPTH / REG_ZERO are the default datapath geometry
//   (64-bit registers, 32 entries, X31 hardwired to zero).
package regfile_pkg;

  localparam int REG_WIDTH = 64;
  localparam int REG_DEPTH = 32;
  localparam int REG_ZERO  = 31;

  // Address bits needed to index 'depth' registers; never less than 1 so a
  // degenerate depth still yields a legal vector width.
  function automatic int addr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/regfile_param_reg_en.sv
// reg_en
//   WIDTH-bit register with load enable and synchronous active-high reset.
//   Reset has priority over the enable; with enable low the value holds.
// Ports:
//   clk   - clock, rising edge
//   reset - synchronous clear to zero
//   en    - load enable
//   d     - next value when en=1
//   q     - registered value
module reg_en
  import regfile_pkg::*;
#(
  parameter int WIDTH = REG_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      q_reg <= '0;
    end else if (en) begin
      q_reg <= d;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/regfile_param.sv
// regfile_param
//   DEPTH x WIDTH register file with one write port and NUM_RD combinational
//   read ports. Register ZERO_REG always reads zero and ignores writes.
//   With BYPASS=1 a read port addressing the register being written in the
//   current cycle sees WriteData directly (zero-cycle forward).
// Ports:
//   clk           - clock, rising edge
//   reset         - synchronous active-high clear of all registers
//   RegWrite      - write enable, sampled at the edge
//   WriteRegister - write address
//   WriteData     - write data
//   ReadRegister  - packed read addresses, port i at [i*AW +: AW]
//   ReadData      - packed read data, port i at [i*WIDTH +: WIDTH]
module regfile_param
  import regfile_pkg::*;
#(
  parameter int WIDTH    = REG_WIDTH,
  parameter int DEPTH    = REG_DEPTH,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = DEPTH - 1,
  parameter int BYPASS   = 0,
  localparam int AW      = addr_width(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    RegWrite,
  input  logic [AW-1:0]           WriteRegister,
  input  logic [WIDTH-1:0]        WriteData,
  input  logic [NUM_RD*AW-1:0]    ReadRegister,
  output logic [NUM_RD*WIDTH-1:0] ReadData
);

  localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

  logic [DEPTH-1:0] wr_en;
  logic [WIDTH-1:0] reg_q [DEPTH];

  // One-hot write decode plus storage. The zero register still gets a
  // storage element (cleared by reset) but its enable is tied low.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
      if (gi == ZERO_REG) begin : g_zero
        assign wr_en[gi] = 1'b0;
      end else begin : g_norm
        assign wr_en[gi] = RegWrite && (WriteRegister == AW'(gi));
      end

      reg_en #(
        .WIDTH(WIDTH)
      ) u_reg (
        .clk  (clk),
        .reset(reset),
        .en   (wr_en[gi]),
        .d    (WriteData),
        .q    (reg_q[gi])
      );
    end
  endgenerate

  // Read muxes. Zero-register override wins over everything, so the bypass
  // needs no separate check that the write target is the zero register.
  generate
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [AW-1:0]    rd_addr;
      logic [WIDTH-1:0] rd_data;

      assign rd_addr = ReadRegister[gi*AW +: AW];

      always_comb begin
        rd_data = reg_q[rd_addr];
        if (rd_addr == ZERO_ADDR) begin
          rd_data = '0;
        end else if ((BYPASS != 0) && !reset && RegWrite &&
                     (WriteRegister == rd_addr)) begin
          rd_data = WriteData;
        end
      end

      assign ReadData[gi*WIDTH +: WIDTH] = rd_data;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param
//   Drives two register files (BYPASS=0 and BYPASS=1) from the same inputs
//   and checks them against an array-based reference model, using directed
//   sequences, a vector table and randomized traffic.
module tb_regfile_param;

  logic         clk;
  logic         reset;
  logic         RegWrite;
  logic [4:0]   WriteRegister;
  logic [63:0]  WriteData;
  logic [9:0]   ReadRegister;
  logic [127:0] rd_nb;
  logic [127:0] rd_bp;

  int tests_run;
  int tests_failed;

  logic [63:0] model [32];

  regfile_param #(.BYPASS(0)) dut_nb (
    .clk          (clk),
    .reset        (reset),
    .RegWrite     (RegWrite),
    .WriteRegister(WriteRegister),
    .WriteData    (WriteData),
    .ReadRegister (ReadRegister),
    .ReadData     (rd_nb)
  );

  regfile_param #(.BYPASS(1)) dut_bp (
    .clk          (clk),
    .reset        (reset),
    .RegWrite     (RegWrite),
    .WriteRegister(WriteRegister),
    .WriteData    (WriteData),
    .ReadRegister (ReadRegister),
    .ReadData     (rd_bp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic        we;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic [4:0]  ra;
    logic [63:0] pre_nb;
    logic [63:0] pre_bp;
    logic [63:0] post;
  } vec_t;

  function automatic logic [63:0] pat(input int i);
    return (i == 31) ? 64'h0 : 64'h0101_0101_0101_0101 * 64'(i);
  endfunction

  // Expected read value from the rules: zero register reads 0, bypass only
  // when enabled, writing, not in reset and addresses match; else storage.
  function automatic logic [63:0] exp_read(input logic [4:0] a, input bit bp);
    if (a == 5'd31) return 64'h0;
    if (bp && !reset && RegWrite && (WriteRegister == a)) return WriteData;
    return model[a];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("[TB] ok   %s: %h", name, act);
    end
  endtask

  task automatic set_in(input logic rst, input logic we, input logic [4:0] wa,
                        input logic [63:0] wd, input logic [4:0] ra0, input logic [4:0] ra1);
    reset         = rst;
    RegWrite      = we;
    WriteRegister = wa;
    WriteData     = wd;
    ReadRegister  = {ra1, ra0};
  endtask

  // Advance one edge and apply the same edge to the model.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int k = 0; k < 32; k++) model[k] = 64'h0;
    end else if (RegWrite && (WriteRegister != 5'd31)) begin
      model[WriteRegister] = WriteData;
    end
    #1;
  endtask

  task automatic check_ports(input string tag);
    chk({tag, "_nb_p0"}, rd_nb[63:0],   exp_read(ReadRegister[4:0], 1'b0));
    chk({tag, "_nb_p1"}, rd_nb[127:64], exp_read(ReadRegister[9:5], 1'b0));
    chk({tag, "_bp_p0"}, rd_bp[63:0],   exp_read(ReadRegister[4:0], 1'b1));
    chk({tag, "_bp_p1"}, rd_bp[127:64], exp_read(ReadRegister[9:5], 1'b1));
  endtask

  vec_t vecs [5];

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    for (int k = 0; k < 32; k++) model[k] = 64'h0;
    set_in(1'b1, 1'b0, 5'd0, 64'h0, 5'd0, 5'd0);
    #2;

    // Reset sequence: write X5, then reset clears it and everything else.
    tick();
    set_in(1'b0, 1'b1, 5'd5, 64'hDEAD_BEEF, 5'd5, 5'd5);
    tick();
    set_in(1'b0, 1'b0, 5'd0, 64'h0, 5'd5, 5'd5);
    #1;
    chk("x5_written", rd_nb[63:0], 64'hDEAD_BEEF);
    set_in(1'b1, 1'b0, 5'd0, 64'h0, 5'd5, 5'd5);
    tick();
    set_in(1'b0, 1'b0, 5'd0, 64'h0, 5'd5, 5'd5);
    #1;
    chk("reset_x5", rd_nb[63:0], 64'h0);
    for (int i = 0; i < 32; i += 2) begin
      set_in(1'b0, 1'b0, 5'd0, 64'h0, 5'(i), 5'(i + 1));
      #1;
      chk($sformatf("reset_all_nb_x%0d", i),     rd_nb[63:0],   64'h0);
      chk($sformatf("reset_all_nb_x%0d", i + 1), rd_nb[127:64], 64'h0);
      chk($sformatf("reset_all_bp_x%0d", i),     rd_bp[63:0],   64'h0);
      chk($sformatf("reset_all_bp_x%0d", i + 1), rd_bp[127:64], 64'h0);
    end

    // Fill X0..X30 with the byte-replicated index pattern.
    for (int i = 0; i < 31; i++) begin
      set_in(1'b0, 1'b1, 5'(i), pat(i), 5'd0, 5'd0);
      tick();
    end
    set_in(1'b0, 1'b0, 5'd0, 64'h0, 5'd0, 5'd0);
    for (int i = 0; i < 32; i += 2) begin
      set_in(1'b0, 1'b0, 5'd0, 64'h0, 5'(i), 5'(i + 1));
      #1;
      chk($sformatf("fill_p0_x%0d", i),     rd_nb[63:0],   pat(i));
      chk($sformatf("fill_p1_x%0d", i + 1), rd_nb[127:64], pat(i + 1));
    end
    for (int i = 0; i < 32; i += 5) begin
      set_in(1'b0, 1'b0, 5'd0, 64'h0, 5'(i), 5'(i));
      #1;
      chk($sformatf("same_addr_p0_x%0d", i), rd_bp[63:0],   pat(i));
      chk($sformatf("same_addr_p1_x%0d", i), rd_bp[127:64], pat(i));
    end

    // Directed corner-case table, applied in order from the filled state.
    vecs[0] = '{"zero_reg_write", 1'b0, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31,
                64'h0, 64'h0, 64'h0};
    vecs[1] = '{"enable_low",     1'b0, 1'b0, 5'd7,  64'h1234, 5'd7,
                pat(7), pat(7), pat(7)};
    vecs[2] = '{"write_x3_11",    1'b0, 1'b1, 5'd3,  64'h11, 5'd3,
                pat(3), 64'h11, 64'h11};
    vecs[3] = '{"bypass_x3_22",   1'b0, 1'b1, 5'd3,  64'h22, 5'd3,
                64'h11, 64'h22, 64'h22};
    vecs[4] = '{"reset_collide",  1'b1, 1'b1, 5'd9,  64'h55, 5'd9,
                pat(9), pat(9), 64'h0};
    for (int v = 0; v < 5; v++) begin
      set_in(vecs[v].rst, vecs[v].we, vecs[v].wa, vecs[v].wd, vecs[v].ra, vecs[v].ra);
      #1;
      chk({vecs[v].name, "_pre_nb_p0"}, rd_nb[63:0],   vecs[v].pre_nb);
      chk({vecs[v].name, "_pre_nb_p1"}, rd_nb[127:64], vecs[v].pre_nb);
      chk({vecs[v].name, "_pre_bp_p0"}, rd_bp[63:0],   vecs[v].pre_bp);
      chk({vecs[v].name, "_pre_bp_p1"}, rd_bp[127:64], vecs[v].pre_bp);
      tick();
      set_in(1'b0, 1'b0, 5'd0, 64'h0, vecs[v].ra, vecs[v].ra);
      #1;
      chk({vecs[v].name, "_post_nb"}, rd_nb[63:0], vecs[v].post);
      chk({vecs[v].name, "_post_bp"}, rd_bp[63:0], vecs[v].post);
    end

    // Randomized traffic against the model; occasional resets.
    for (int n = 0; n < 300; n++) begin
      logic [4:0] wa;
      logic [4:0] ra0;
      logic [4:0] ra1;
      wa  = 5'($urandom_range(0, 31));
      ra0 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      ra1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      set_in(($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)), wa,
             {$urandom, $urandom}, ra0, ra1);
      #1;
      check_ports($sformatf("rand%0d", n));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
